// File: rtl/accel_sketch_ocimem_pkg.sv
// ---------------------------------------------------------------------------
// accel_sketch_ocimem_pkg: shared types and jdo field offsets for the OCI
// debug-RAM arbiter.                                         Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package accel_sketch_ocimem_pkg;

  localparam int JDO_W     = 38;
  localparam int ADDR_LSB  = 18;
  localparam int RDFLAG    = 17;
  localparam int WDATA_LSB = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_JT_RD = 2'd1,
    ST_AV_RD = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2
  } jop_e;

  // Reset value of last_grant is 0, i.e. Avalon.
  typedef enum logic {
    GNT_AV   = 1'b0,
    GNT_JTAG = 1'b1
  } grant_e;

endpackage

`default_nettype wire

// File: rtl/accel_sketch_nios2_gen2_0_cpu_ocimem_jcmd.sv
// ---------------------------------------------------------------------------
// accel_sketch_nios2_gen2_0_cpu_ocimem_jcmd: JTAG strobe precedence, one-deep
// pending command register and sticky overrun flag.          Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module accel_sketch_nios2_gen2_0_cpu_ocimem_jcmd
  import accel_sketch_ocimem_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [JDO_W-1:0] jdo_i,
  input  logic             take_a_i,
  input  logic             take_b_i,
  input  logic             take_no_a_i,
  input  logic             consume_i,
  output logic             pend_o,
  output jop_e             op_o,
  output logic [JDO_W-1:0] jdo_o,
  output logic             overrun_o
);

  logic             pend_q, pend_d;
  jop_e             op_q, op_d;
  logic [JDO_W-1:0] jdo_q, jdo_d;
  logic             overrun_q, overrun_d;

  logic w_any;
  logic w_multi;
  logic w_accept;

  assign w_any    = take_a_i | take_b_i | take_no_a_i;
  assign w_multi  = (take_a_i & take_b_i) | (take_a_i & take_no_a_i) | (take_b_i & take_no_a_i);
  // The slot frees up in the same cycle the arbiter consumes it.
  assign w_accept = ~pend_q | consume_i;

  always_comb begin
    pend_d    = pend_q & ~consume_i;
    op_d      = op_q;
    jdo_d     = jdo_q;
    overrun_d = overrun_q | (w_any & (w_multi | ~w_accept));
    if (w_any && w_accept) begin
      pend_d = 1'b1;
      jdo_d  = jdo_i;
      if (take_a_i) begin
        op_d = OP_LOAD;
      end else if (take_b_i) begin
        op_d = OP_WRITE;
      end else begin
        op_d = OP_READ;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q    <= 1'b0;
      op_q      <= OP_LOAD;
      jdo_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      op_q      <= op_d;
      jdo_q     <= jdo_d;
      overrun_q <= overrun_d;
    end
  end

  assign pend_o    = pend_q;
  assign op_o      = op_q;
  assign jdo_o     = jdo_q;
  assign overrun_o = overrun_q;

endmodule

`default_nettype wire

// File: rtl/accel_sketch_nios2_gen2_0_cpu_ocimem_arbiter.sv
// ---------------------------------------------------------------------------
// accel_sketch_nios2_gen2_0_cpu_ocimem_arbiter: alternating-priority sharing
// of the OCI debug RAM between JTAG commands and Avalon.     Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module accel_sketch_nios2_gen2_0_cpu_ocimem_arbiter
  import accel_sketch_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  input  logic [3:0]        avs_byteenable,
  input  logic              debugaccess,
  output logic              avs_waitrequest,
  output logic [DATA_W-1:0] avs_readdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rden,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [3:0]        ram_be,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              mon_valid,
  output logic              jtag_overrun
);

  state_e            state_q, state_d;
  grant_e            last_q, last_d;
  logic [ADDR_W-1:0] jtag_addr_q, jtag_addr_d;
  logic [31:0]       mon_dreg_q, mon_dreg_d;
  logic              mon_valid_q, mon_valid_d;

  logic              w_pend;
  jop_e              w_op;
  logic [JDO_W-1:0]  w_jdo;
  logic              w_consume;
  logic [ADDR_W-1:0] w_load_addr;
  logic              w_av_req;
  logic              w_jt_grant;

  logic              w_rden;
  logic              w_wren;
  logic              w_wait;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [3:0]        w_be;
  logic              w_unused;

  accel_sketch_nios2_gen2_0_cpu_ocimem_jcmd u_jcmd (
    .clk         (clk),
    .reset_n     (reset_n),
    .jdo_i       (jdo),
    .take_a_i    (take_action_ocimem_a),
    .take_b_i    (take_action_ocimem_b),
    .take_no_a_i (take_no_action_ocimem_a),
    .consume_i   (w_consume),
    .pend_o      (w_pend),
    .op_o        (w_op),
    .jdo_o       (w_jdo),
    .overrun_o   (jtag_overrun)
  );

  assign w_load_addr = w_jdo[ADDR_LSB +: ADDR_W];
  assign w_av_req    = avs_read | avs_write;
  // JTAG yields only when it won the previous grant and Avalon is waiting.
  assign w_jt_grant  = w_pend & ~(w_av_req & (last_q == GNT_JTAG));
  assign w_unused    = &{1'b0, w_jdo[JDO_W-1:WDATA_LSB+32], w_jdo[WDATA_LSB-1:0]};

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    jtag_addr_d = jtag_addr_q;
    mon_dreg_d  = mon_dreg_q;
    mon_valid_d = 1'b0;
    w_consume   = 1'b0;
    w_rden      = 1'b0;
    w_wren      = 1'b0;
    w_wait      = 1'b1;
    w_addr      = jtag_addr_q;
    w_wdata     = DATA_W'(w_jdo[WDATA_LSB +: 32]);
    w_be        = 4'hF;
    unique case (state_q)
      ST_IDLE: begin
        if (w_jt_grant) begin
          w_consume = 1'b1;
          last_d    = GNT_JTAG;
          unique case (w_op)
            OP_LOAD: begin
              jtag_addr_d = w_load_addr;
              if (w_jdo[RDFLAG]) begin
                w_rden  = 1'b1;
                w_addr  = w_load_addr;
                state_d = ST_JT_RD;
              end
            end
            OP_WRITE: begin
              w_wren      = 1'b1;
              jtag_addr_d = jtag_addr_q + 1'b1;
            end
            default: begin
              w_rden  = 1'b1;
              state_d = ST_JT_RD;
            end
          endcase
        end else if (avs_read) begin
          w_rden  = 1'b1;
          w_addr  = avs_address;
          state_d = ST_AV_RD;
        end else if (avs_write) begin
          w_wren  = debugaccess;
          w_wait  = 1'b0;
          w_addr  = avs_address;
          w_wdata = avs_writedata;
          w_be    = avs_byteenable;
          last_d  = GNT_AV;
        end
      end
      ST_JT_RD: begin
        mon_dreg_d  = ram_rdata[31:0];
        mon_valid_d = 1'b1;
        jtag_addr_d = jtag_addr_q + 1'b1;
        last_d      = GNT_JTAG;
        state_d     = ST_IDLE;
      end
      ST_AV_RD: begin
        w_wait  = 1'b0;
        last_d  = GNT_AV;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      last_q      <= GNT_AV;
      jtag_addr_q <= '0;
      mon_dreg_q  <= '0;
      mon_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      jtag_addr_q <= jtag_addr_d;
      mon_dreg_q  <= mon_dreg_d;
      mon_valid_q <= mon_valid_d;
    end
  end

  // Enables are forced off while reset is held so nothing reaches the RAM.
  assign ram_rden        = w_rden & reset_n;
  assign ram_wren        = w_wren & reset_n;
  assign avs_waitrequest = w_wait | ~reset_n;
  assign ram_addr        = w_addr;
  assign ram_wdata       = w_wdata;
  assign ram_be          = w_be;
  assign avs_readdata    = ram_rdata;
  assign MonDReg         = mon_dreg_q;
  assign mon_valid       = mon_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_accel_sketch_nios2_gen2_0_cpu_ocimem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_accel_sketch_nios2_gen2_0_cpu_ocimem_arbiter: scoreboard bench with a
// RAM model and a shadow-memory reference.                   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_accel_sketch_nios2_gen2_0_cpu_ocimem_arbiter;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic              clk;
  logic              reset_n;
  logic [37:0]       jdo;
  logic              take_a, take_b, take_na;
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read, avs_write;
  logic [DATA_W-1:0] avs_writedata;
  logic [3:0]        avs_byteenable;
  logic              debugaccess;
  logic              avs_waitrequest;
  logic [DATA_W-1:0] avs_readdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rden, ram_wren;
  logic [DATA_W-1:0] ram_wdata;
  logic [3:0]        ram_be;
  logic [DATA_W-1:0] ram_rdata;
  logic [31:0]       MonDReg;
  logic              mon_valid;
  logic              jtag_overrun;

  accel_sketch_nios2_gen2_0_cpu_ocimem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_a),
    .take_action_ocimem_b    (take_b),
    .take_no_action_ocimem_a (take_na),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .debugaccess             (debugaccess),
    .avs_waitrequest         (avs_waitrequest),
    .avs_readdata            (avs_readdata),
    .ram_addr                (ram_addr),
    .ram_rden                (ram_rden),
    .ram_wren                (ram_wren),
    .ram_wdata               (ram_wdata),
    .ram_be                  (ram_be),
    .ram_rdata               (ram_rdata),
    .MonDReg                 (MonDReg),
    .mon_valid               (mon_valid),
    .jtag_overrun            (jtag_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic [7:0]  ref_jaddr;
  logic [31:0] exp_mon [$];
  logic [31:0] exp_av  [$];
  logic [7:0]  last_waddr;
  logic [31:0] last_wdata;
  logic [3:0]  last_be;

  function automatic logic [31:0] pat(input int a);
    logic [7:0] b;
    b = a[7:0];
    return {b, ~b, b ^ 8'h5A, b + 8'h33};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Single-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_rden) ram_rdata <= mem[ram_addr];
    if (ram_wren) mem[ram_addr] <= merge(mem[ram_addr], ram_wdata, ram_be);
  end

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge clk) begin
    if (reset_n) begin
      if (mon_valid) begin
        if (exp_mon.size() == 0) check("unexpected_mon_valid", 64'(mon_valid), 64'd0);
        else check("mondreg", 64'(MonDReg), 64'(exp_mon.pop_front()));
      end
      if (avs_read && !avs_waitrequest) begin
        if (exp_av.size() == 0) check("unexpected_av_ack", 64'(avs_waitrequest), 64'd1);
        else check("avs_readdata", 64'(avs_readdata), 64'(exp_av.pop_front()));
      end
      if (ram_wren) begin
        last_waddr = ram_addr;
        last_wdata = ram_wdata;
        last_be    = ram_be;
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic jt_strobe(input int kind, input logic [37:0] d);
    jdo     = d;
    take_a  = (kind == 0);
    take_b  = (kind == 1);
    take_na = (kind == 2);
    @(posedge clk); #1;
    take_a = 1'b0; take_b = 1'b0; take_na = 1'b0;
  endtask

  task automatic jt_load(input logic [7:0] a, input logic rd);
    ref_jaddr = a;
    if (rd) begin
      exp_mon.push_back(ref_mem[ref_jaddr]);
      ref_jaddr = ref_jaddr + 8'd1;
    end
    jt_strobe(0, (38'(a) << 18) | (38'(rd) << 17));
  endtask

  task automatic jt_write(input logic [31:0] d);
    ref_mem[ref_jaddr] = d;
    ref_jaddr = ref_jaddr + 8'd1;
    jt_strobe(1, 38'(d) << 3);
  endtask

  task automatic jt_read();
    exp_mon.push_back(ref_mem[ref_jaddr]);
    ref_jaddr = ref_jaddr + 8'd1;
    jt_strobe(2, 38'($urandom));
  endtask

  task automatic av_read(input logic [7:0] a, input int maxlat, input logic also_write);
    int lat;
    logic done;
    exp_av.push_back(ref_mem[a]);
    avs_address   = a;
    avs_read      = 1'b1;
    avs_write     = also_write;
    avs_writedata = $urandom;
    debugaccess   = also_write;
    lat = 0; done = 1'b0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (!avs_waitrequest) done = 1'b1;
    end
    check("av_rd_latency", 64'(done && lat <= maxlat), 64'd1);
    @(posedge clk); #1;
    avs_read = 1'b0; avs_write = 1'b0; debugaccess = 1'b0;
  endtask

  task automatic av_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                          input logic dbg, input int maxlat);
    int lat;
    logic done;
    logic wren_seen;
    avs_address = a; avs_write = 1'b1; avs_writedata = d;
    avs_byteenable = be; debugaccess = dbg;
    lat = 0; done = 1'b0; wren_seen = 1'b0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (!avs_waitrequest) begin
        done = 1'b1;
        wren_seen = ram_wren;
      end
    end
    check("av_wr_latency", 64'(done && lat <= maxlat), 64'd1);
    check("av_wr_wren", 64'(wren_seen), 64'(dbg));
    if (dbg) ref_mem[a] = merge(ref_mem[a], d, be);
    @(posedge clk); #1;
    avs_write = 1'b0; debugaccess = 1'b0; avs_byteenable = 4'hF;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_mon.size() != 0 || exp_av.size() != 0) && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("scoreboard_drained", 64'(exp_mon.size() + exp_av.size()), 64'd0);
  endtask

  task automatic summary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    summary();
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = pat(i);
      ref_mem[i] = pat(i);
    end
    ref_jaddr = 8'd0;
    reset_n = 1'b0; jdo = '0; take_a = 0; take_b = 0; take_na = 0;
    avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0;
    avs_byteenable = 4'hF; debugaccess = 0; ram_rdata = '0;
    #23;
    check("rst_rden", 64'(ram_rden), 64'd0);
    check("rst_wren", 64'(ram_wren), 64'd0);
    check("rst_mondreg", 64'(MonDReg), 64'd0);
    check("rst_mon_valid", 64'(mon_valid), 64'd0);
    check("rst_overrun", 64'(jtag_overrun), 64'd0);
    check("rst_waitreq", 64'(avs_waitrequest), 64'd1);
    @(negedge clk); reset_n = 1'b1;
    wait_cycles(2);
    check("idle_waitreq", 64'(avs_waitrequest), 64'd1);

    // LOAD 0x10 with read flag, then a plain READ proves the pointer moved to 0x11.
    mem[8'h10] = 32'hDEADBEEF; ref_mem[8'h10] = 32'hDEADBEEF;
    jt_load(8'h10, 1'b1);
    wait_cycles(1);
    check("load_rd_mon_valid_early", 64'(mon_valid), 64'd0);
    wait_cycles(1);
    check("load_rd_mon_valid", 64'(mon_valid), 64'd1);
    check("load_rd_mondreg", 64'(MonDReg), 64'hDEADBEEF);
    wait_cycles(2);
    jt_read();
    drain();

    // Pointer wrap at the top of the RAM.
    jt_load(8'hFF, 1'b0);
    wait_cycles(3);
    jt_write(32'h12345678);
    wait_cycles(3);
    check("jwr_addr", 64'(last_waddr), 64'hFF);
    check("jwr_data", 64'(last_wdata), 64'h12345678);
    check("jwr_be", 64'(last_be), 64'hF);
    jt_read();
    drain();
    jt_load(8'hFF, 1'b1);
    drain();
    wait_cycles(2);

    // Avalon paths.
    av_read(8'h20, 2, 1'b0);
    av_write(8'h30, 32'hCAFEF00D, 4'hF, 1'b0, 1);
    av_read(8'h30, 2, 1'b0);
    av_write(8'h31, 32'hA1B2C3D4, 4'b0101, 1'b1, 1);
    av_read(8'h31, 2, 1'b0);
    av_read(8'h32, 2, 1'b1);
    av_read(8'h32, 2, 1'b0);
    drain();

    // Contention: Avalon reads back-to-back while JTAG reads keep arriving.
    fork
      begin
        for (int i = 0; i < 10; i++) av_read(8'($urandom_range(0, 255)), 4, 1'b0);
      end
      begin
        for (int j = 0; j < 6; j++) begin
          jt_read();
          wait_cycles(4);
        end
      end
    join
    drain();
    check("no_overrun_after_contention", 64'(jtag_overrun), 64'd0);

    // Randomized serialized traffic.
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 4))
        0: begin jt_load(8'($urandom_range(0, 255)), 1'($urandom)); wait_cycles(5); end
        1: begin jt_write($urandom); wait_cycles(5); end
        2: begin jt_read(); wait_cycles(5); end
        3: av_read(8'($urandom_range(0, 255)), 2, 1'b0);
        default: av_write(8'($urandom_range(0, 255)), $urandom, 4'($urandom), 1'($urandom), 1);
      endcase
    end
    drain();
    check("no_overrun_random", 64'(jtag_overrun), 64'd0);

    // LOAD and WRITE together: LOAD wins, WRITE is lost.
    ref_jaddr = 8'h40;
    exp_mon.push_back(ref_mem[8'h40]);
    ref_jaddr = 8'h41;
    jdo = (38'(8'h40) << 18) | (38'd1 << 17);
    take_a = 1'b1; take_b = 1'b1;
    @(posedge clk); #1;
    take_a = 1'b0; take_b = 1'b0;
    drain();
    check("overrun_set", 64'(jtag_overrun), 64'd1);
    jt_read();
    drain();
    wait_cycles(10);
    check("overrun_sticky", 64'(jtag_overrun), 64'd1);

    // Asynchronous reset in the middle of an Avalon read.
    avs_address = 8'h20; avs_read = 1'b1;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("midrst_rden", 64'(ram_rden), 64'd0);
    check("midrst_wren", 64'(ram_wren), 64'd0);
    check("midrst_mondreg", 64'(MonDReg), 64'd0);
    check("midrst_overrun", 64'(jtag_overrun), 64'd0);
    check("midrst_waitreq", 64'(avs_waitrequest), 64'd1);
    avs_read = 1'b0;
    wait_cycles(2);
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("postrst_waitreq", 64'(avs_waitrequest), 64'd1);
    end
    @(posedge clk); #1;
    ref_jaddr = 8'd0;
    jt_read();
    drain();

    summary();
    $finish;
  end

endmodule

`default_nettype wire
